// File: rtl/cont4bits_secuenciador_pkg.sv
// Shared definitions for the lap sequencer and its 4-bit counter datapath:
// state encoding, counter width and small decode helpers.
package cont4bits_secuenciador_pkg;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // A run is in progress while counting or paused.
    function automatic logic is_busy(input seq_state_e st);
        logic b;
        case (st)
            ST_RUN:  b = 1'b1;
            ST_HOLD: b = 1'b1;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic is_done(input seq_state_e st);
        return (st == ST_DONE);
    endfunction

endpackage

// File: rtl/cont4bits_secuenciador_clr.sv
// Mod-16 counter with synchronous clear (priority over enable) and a
// terminal-count strobe that is only raised while counting.
module cont4bits_clr
    import cont4bits_secuenciador_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             enable,
    output logic [CNT_W-1:0] Q,
    output logic             TC
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance when enabled (15 wraps to 0).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q  = cnt_q;
    assign TC = enable & (cnt_q == CNT_MAX);

endmodule

// File: rtl/cont4bits_secuenciador.sv
// Lap sequencer: runs the mod-16 counter for a latched number of full laps,
// with level pause and a highest-priority abort.
module cont4bits_secuenciador
    import cont4bits_secuenciador_pkg::*;
#(
    parameter int LAP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic [LAP_W-1:0] n_laps,
    output logic [CNT_W-1:0] q,
    output logic [LAP_W-1:0] lap,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [LAP_W-1:0] LAP_ZERO = {LAP_W{1'b0}};
    localparam logic [LAP_W-1:0] LAP_ONE  = {{(LAP_W-1){1'b0}}, 1'b1};

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [LAP_W-1:0] lap_q;
    logic [LAP_W-1:0] lap_d;
    logic [LAP_W-1:0] laps_q;
    logic [LAP_W-1:0] laps_d;
    logic             aborted_q;
    logic             aborted_d;

    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             cnt_tc_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic [LAP_W-1:0] lap_inc_s;

    cont4bits_clr u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr_s),
        .enable  (cnt_en_s),
        .Q       (cnt_val_s),
        .TC      (cnt_tc_s)
    );

    assign lap_inc_s = lap_q + LAP_ONE;

    // Next state, lap bookkeeping and counter control.
    always_comb begin
        state_d   = state_q;
        lap_d     = lap_q;
        laps_d    = laps_q;
        aborted_d = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_clr_s = 1'b1;
                    lap_d     = LAP_ZERO;
                    laps_d    = n_laps;
                    if (n_laps != LAP_ZERO) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (stop) begin
                    // q and lap are intentionally left as they are.
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else begin
                    // Leaving HOLD counts in the same cycle pause drops.
                    cnt_en_s = 1'b1;
                    state_d  = ST_RUN;
                    if (cnt_tc_s) begin
                        lap_d = lap_inc_s;
                        if (lap_inc_s == laps_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        lap_d = lap_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            lap_q     <= LAP_ZERO;
            laps_q    <= LAP_ZERO;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lap_q     <= lap_d;
            laps_q    <= laps_d;
            aborted_q <= aborted_d;
        end
    end

    assign q       = cnt_val_s;
    assign lap     = lap_q;
    assign busy    = is_busy(state_q);
    assign done    = is_done(state_q);
    assign aborted = aborted_q;

endmodule

// File: tb/tb_cont4bits_secuenciador.sv
// Self-checking bench for cont4bits_secuenciador: a scoreboard of expected
// done/aborted events plus per-cycle checks of q, lap and busy.
module tb_cont4bits_secuenciador;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic       stop;
    logic [3:0] n_laps;
    logic [3:0] q;
    logic [3:0] lap;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_checks;
    int n_errors;
    int cyc;

    typedef struct {
        logic       kind;   // 0 = done, 1 = aborted
        int         cyc;
        logic [3:0] q;
        logic [3:0] lap;
    } exp_t;

    exp_t sb[$];

    cont4bits_secuenciador #(.LAP_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .pause   (pause),
        .stop    (stop),
        .n_laps  (n_laps),
        .q       (q),
        .lap     (lap),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Event monitor: every done/aborted pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && (done || aborted)) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_event", {30'd0, done, aborted}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sb_kind", {31'd0, aborted}, {31'd0, e.kind});
                check_eq("sb_cycle", cyc, e.cyc);
                check_eq("sb_q", {28'd0, q}, {28'd0, e.q});
                check_eq("sb_lap", {28'd0, lap}, {28'd0, e.lap});
            end
        end
    end

    // Pulse start for one cycle; the expected done lands 1+16*N(+pause) cycles later.
    task automatic start_run(input int nl, input int extra, input bit push_done);
        exp_t e;
        n_laps = nl[3:0];
        start  = 1'b1;
        if (push_done) begin
            e.kind = 1'b0;
            e.cyc  = cyc + 1 + 16 * nl + extra;
            e.q    = 4'd0;
            e.lap  = nl[3:0];
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ql(input logic [3:0] qv, input logic [3:0] lv);
        int n;
        n = 0;
        while (!(q == qv && lap == lv) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_q_lap", {31'd0, (q == qv && lap == lv)}, 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_done", {31'd0, done}, 32'd1);
    endtask

    task automatic stop_now(input logic [3:0] qv, input logic [3:0] lv);
        exp_t e;
        e.kind = 1'b1;
        e.cyc  = cyc + 1;
        e.q    = qv;
        e.lap  = lv;
        sb.push_back(e);
        stop = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        pause = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_q", {28'd0, q}, {28'd0, qv});
        check_eq("abort_lap", {28'd0, lap}, {28'd0, lv});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        stop     = 1'b0;
        n_laps   = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_q", {28'd0, q}, 32'd0);
        check_eq("rst_lap", {28'd0, lap}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_aborted", {31'd0, aborted}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a run.
        start_run(2, 0, 1'b1);
        wait_ql(4'd7, 4'd0);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_q", {28'd0, q}, 32'd0);
        check_eq("mid_rst_lap", {28'd0, lap}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two full laps, checked every cycle.
        start_run(2, 0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            check_eq("run_q", {28'd0, q}, i % 16);
            check_eq("run_lap", {28'd0, lap}, i / 16);
            check_eq("run_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check_eq("run_done", {31'd0, done}, 32'd1);
        check_eq("run_done_busy", {31'd0, busy}, 32'd0);
        check_eq("run_done_lap", {28'd0, lap}, 32'd2);
        @(negedge clk);
        check_eq("run_after_done", {31'd0, done}, 32'd0);
        check_eq("run_after_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        // Pause for five cycles at q=4 delays done by five cycles.
        start_run(1, 5, 1'b1);
        wait_ql(4'd4, 4'd0);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_q", {28'd0, q}, 32'd4);
            check_eq("hold_busy", {31'd0, busy}, 32'd1);
        end
        pause = 1'b0;
        wait_done(30);
        repeat (2) @(negedge clk);

        // Abort at q=9 lap=1: values retained, no done.
        start_run(3, 0, 1'b0);
        wait_ql(4'd9, 4'd1);
        stop_now(4'd9, 4'd1);
        repeat (3) @(negedge clk);
        check_eq("abort_idle_q", {28'd0, q}, 32'd9);
        check_eq("abort_idle_lap", {28'd0, lap}, 32'd1);

        // Zero laps: done next cycle, counter stays at zero; stop in DONE ignored.
        start_run(0, 0, 1'b1);
        check_eq("zero_done", {31'd0, done}, 32'd1);
        check_eq("zero_q", {28'd0, q}, 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("zero_no_abort", {31'd0, aborted}, 32'd0);
        check_eq("zero_idle_q", {28'd0, q}, 32'd0);
        repeat (2) @(negedge clk);

        // Start while busy with a different n_laps does not change the run.
        start_run(1, 0, 1'b1);
        repeat (2) @(negedge clk);
        n_laps = 4'd5;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_laps = 4'd0;
        wait_done(40);
        check_eq("busy_start_lap", {28'd0, lap}, 32'd1);
        repeat (2) @(negedge clk);

        // Stop and pause together: stop wins.
        start_run(2, 0, 1'b0);
        wait_ql(4'd3, 4'd0);
        pause = 1'b1;
        stop_now(4'd3, 4'd0);
        repeat (3) @(negedge clk);

        check_eq("sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
